adxl_sample_fifo: RTL and testbench



---
 rtl/adxl_fifo_pkg.sv | 36 +++
 rtl/adxl_fifo_mem.sv | 25 ++
 rtl/adxl_sample_fifo.sv | 168 ++++++++++++++++
 tb/tb_adxl_sample_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adxl_fifo_pkg.sv
// Shared types and constants for the ADXL sample FIFO.
package adxl_fifo_pkg;

  localparam int unsigned FIFO_DEPTH = 96;
  localparam int unsigned DATA_W     = 20;
  localparam int unsigned ENTRY_W    = 21;
  localparam int unsigned PTR_W      = 7;
  localparam int unsigned CNT_W      = 7;

  localparam logic [7:0] EMPTY_BYTE2 = 8'h02;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_X = 2'd1,
    WR_Y = 2'd2,
    WR_Z = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    BP_0 = 2'd0,
    BP_1 = 2'd1,
    BP_2 = 2'd2
  } byte_phase_t;

  // One stored axis entry: sample data plus X-axis marker in the LSB.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              x_marker;
  } fifo_entry_t;

  // Ring pointer increment, wrapping after the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/adxl_fifo_mem.sv
// Entry storage: one write port, one synchronous read port, no reset.
module adxl_fifo_mem
  import adxl_fifo_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  fifo_entry_t      wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output fifo_entry_t      rd_data
);

  fifo_entry_t mem [FIFO_DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adxl_sample_fifo.sv
// Sample FIFO: triplet write sequencer, byte-serial read side, level flags.
module adxl_sample_fifo
  import adxl_fifo_pkg::*;
(
  input  logic              mems_clk,
  input  logic              rst,
  input  logic              samp_valid,
  input  logic [DATA_W-1:0] xdata_in,
  input  logic [DATA_W-1:0] ydata_in,
  input  logic [DATA_W-1:0] zdata_in,
  input  logic [CNT_W-1:0]  fifo_samples,
  input  logic              standby,
  input  logic              cs_n,
  input  logic              fifo_rd_en,
  input  logic              ovr_clr,
  output logic [7:0]        fifo_data_in,
  output logic [CNT_W-1:0]  FIFO_ENTRIES_in,
  output logic              fifo_full,
  output logic              FIFO_OVR
);

  seq_state_t        state;
  logic [DATA_W-1:0] x_q, y_q, z_q;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  entries;
  byte_phase_t       bp;
  logic              rd_empty;
  logic              cs_n_q;
  fifo_entry_t       wr_data, rd_data;

  logic             wr_en_c, space_ok_c, samp_drop_c, rd_adv_c, pop_c, cs_rise_c;
  logic             empty_view_c;
  logic [CNT_W-1:0] wm_c;

  // Write/pop qualifiers and effective watermark.
  always_comb begin
    wr_en_c      = (state != IDLE) && !standby;
    space_ok_c   = (8'(entries) + 8'd3) <= 8'(FIFO_DEPTH);
    samp_drop_c  = samp_valid && !standby && ((state != IDLE) || !space_ok_c);
    rd_adv_c     = fifo_rd_en && !standby;
    pop_c        = rd_adv_c && (bp == BP_2) && !rd_empty;
    cs_rise_c    = cs_n && !cs_n_q;
    empty_view_c = rd_empty || ((bp == BP_0) && (entries == '0));
    wm_c         = (fifo_samples > CNT_W'(FIFO_DEPTH)) ? CNT_W'(FIFO_DEPTH) : fifo_samples;
    case (state)
      WR_X:    wr_data = '{data: x_q, x_marker: 1'b1};
      WR_Y:    wr_data = '{data: y_q, x_marker: 1'b0};
      default: wr_data = '{data: z_q, x_marker: 1'b0};
    endcase
  end

  // Write sequencer: latch a triplet, then write X, Y, Z on successive cycles.
  always_ff @(posedge mems_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else if (standby) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (samp_valid && space_ok_c) begin
            x_q   <= xdata_in;
            y_q   <= ydata_in;
            z_q   <= zdata_in;
            state <= WR_X;
          end
        end
        WR_X:    state <= WR_Y;
        WR_Y:    state <= WR_Z;
        default: state <= IDLE;
      endcase
    end
  end

  // Write pointer.
  always_ff @(posedge mems_clk or posedge rst) begin
    if (rst)           wr_ptr <= '0;
    else if (standby)  wr_ptr <= '0;
    else if (wr_en_c)  wr_ptr <= ptr_inc(wr_ptr);
  end

  // Read side: byte phase, empty-triplet latch, head pointer, burst restart.
  always_ff @(posedge mems_clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      bp       <= BP_0;
      rd_empty <= 1'b0;
      cs_n_q   <= 1'b1;
    end else begin
      cs_n_q <= cs_n;
      if (standby) begin
        rd_ptr   <= '0;
        bp       <= BP_0;
        rd_empty <= 1'b0;
      end else begin
        if (rd_adv_c) begin
          case (bp)
            BP_0: begin
              bp       <= BP_1;
              rd_empty <= (entries == '0);
            end
            BP_1:    bp <= BP_2;
            default: begin
              bp       <= BP_0;
              rd_empty <= 1'b0;
            end
          endcase
        end
        if (pop_c) rd_ptr <= ptr_inc(rd_ptr);
        // A partially read entry stays at the head and is re-read from byte 0.
        if (cs_rise_c && (bp != BP_0)) begin
          bp       <= BP_0;
          rd_empty <= 1'b0;
        end
      end
    end
  end

  // Committed entry count.
  always_ff @(posedge mems_clk or posedge rst) begin
    if (rst)              entries <= '0;
    else if (standby)     entries <= '0;
    else if (wr_en_c && !pop_c) entries <= entries + CNT_W'(1);
    else if (!wr_en_c && pop_c) entries <= entries - CNT_W'(1);
  end

  // Watermark and sticky overrun flags; overrun set beats clear.
  always_ff @(posedge mems_clk or posedge rst) begin
    if (rst) begin
      fifo_full <= 1'b0;
      FIFO_OVR  <= 1'b0;
    end else begin
      fifo_full <= (wm_c != '0) && (entries >= wm_c);
      if (samp_drop_c)  FIFO_OVR <= 1'b1;
      else if (ovr_clr) FIFO_OVR <= 1'b0;
    end
  end

  // Output byte register.
  always_ff @(posedge mems_clk or posedge rst) begin
    if (rst) begin
      fifo_data_in <= 8'h00;
    end else if (empty_view_c) begin
      fifo_data_in <= (bp == BP_2) ? EMPTY_BYTE2 : 8'h00;
    end else begin
      case (bp)
        BP_0:    fifo_data_in <= rd_data.data[19:12];
        BP_1:    fifo_data_in <= rd_data.data[11:4];
        default: fifo_data_in <= {rd_data.data[3:0], 3'b000, rd_data.x_marker};
      endcase
    end
  end

  assign FIFO_ENTRIES_in = entries;

  adxl_fifo_mem u_mem (
    .clk     (mems_clk),
    .wr_en   (wr_en_c),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_adxl_sample_fifo.sv
// Scoreboard bench for adxl_sample_fifo.
module tb_adxl_sample_fifo;

  logic        mems_clk = 1'b0;
  logic        rst;
  logic        samp_valid;
  logic [19:0] xdata_in, ydata_in, zdata_in;
  logic [6:0]  fifo_samples;
  logic        standby;
  logic        cs_n;
  logic        fifo_rd_en;
  logic        ovr_clr;
  logic [7:0]  fifo_data_in;
  logic [6:0]  FIFO_ENTRIES_in;
  logic        fifo_full;
  logic        FIFO_OVR;

  int vectors    = 0;
  int miscompares = 0;
  int model_entries = 0;
  logic [7:0] exp_q[$];

  adxl_sample_fifo dut (
    .mems_clk        (mems_clk),
    .rst             (rst),
    .samp_valid      (samp_valid),
    .xdata_in        (xdata_in),
    .ydata_in        (ydata_in),
    .zdata_in        (zdata_in),
    .fifo_samples    (fifo_samples),
    .standby         (standby),
    .cs_n            (cs_n),
    .fifo_rd_en      (fifo_rd_en),
    .ovr_clr         (ovr_clr),
    .fifo_data_in    (fifo_data_in),
    .FIFO_ENTRIES_in (FIFO_ENTRIES_in),
    .fifo_full       (fifo_full),
    .FIFO_OVR        (FIFO_OVR)
  );

  always #5 mems_clk = ~mems_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge mems_clk);
      #1;
    end
  endtask

  task automatic push_entry(input logic [19:0] d, input logic xm);
    exp_q.push_back(d[19:12]);
    exp_q.push_back(d[11:4]);
    exp_q.push_back({d[3:0], 3'b000, xm});
  endtask

  // Drive one triplet and record what the FIFO should do with it.
  task automatic push_triplet(input logic [19:0] x, input logic [19:0] y, input logic [19:0] z);
    xdata_in = x; ydata_in = y; zdata_in = z;
    samp_valid = 1'b1;
    tick(1);
    samp_valid = 1'b0;
    tick(5);
    if (model_entries + 3 <= 96) begin
      push_entry(x, 1'b1);
      push_entry(y, 1'b0);
      push_entry(z, 1'b0);
      model_entries += 3;
    end
  endtask

  // Compare the byte currently presented against scoreboard slot idx.
  task automatic read_byte(input int idx, input bit pulse);
    logic [7:0] e;
    tick(3);
    @(negedge mems_clk);
    if (exp_q.size() > idx) begin
      e = exp_q[idx];
      check_val("rd_byte", 32'(fifo_data_in), 32'(e));
    end else begin
      check_val("rd_byte_noexp", 32'(exp_q.size()), 32'(idx + 1));
    end
    if (pulse) begin
      fifo_rd_en = 1'b1;
      @(posedge mems_clk);
      #1;
      fifo_rd_en = 1'b0;
    end
  endtask

  task automatic read_entry();
    read_byte(0, 1'b1);
    read_byte(1, 1'b1);
    read_byte(2, 1'b1);
    repeat (3) if (exp_q.size() > 0) void'(exp_q.pop_front());
    model_entries--;
    check_val("entries_pop", 32'(FIFO_ENTRIES_in), 32'(model_entries));
  endtask

  task automatic read_empty_triplet();
    for (int i = 0; i < 3; i++) begin
      tick(3);
      @(negedge mems_clk);
      check_val("empty_byte", 32'(fifo_data_in), (i == 2) ? 32'h02 : 32'h00);
      fifo_rd_en = 1'b1;
      @(posedge mems_clk);
      #1;
      fifo_rd_en = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; samp_valid = 1'b0; xdata_in = '0; ydata_in = '0; zdata_in = '0;
    fifo_samples = 7'd0; standby = 1'b0; cs_n = 1'b0; fifo_rd_en = 1'b0; ovr_clr = 1'b0;
    tick(3);
    @(negedge mems_clk);
    check_val("rst_data", 32'(fifo_data_in), 32'h00);
    check_val("rst_entries", 32'(FIFO_ENTRIES_in), 32'd0);
    check_val("rst_full", 32'(fifo_full), 32'd0);
    check_val("rst_ovr", 32'(FIFO_OVR), 32'd0);
    rst = 1'b0;
    tick(2);

    // Empty reads.
    read_empty_triplet();
    check_val("empty_entries", 32'(FIFO_ENTRIES_in), 32'd0);

    // Single triplet, byte formatting.
    push_triplet(20'hABCDE, 20'h12345, 20'h0000F);
    check_val("trip_entries", 32'(FIFO_ENTRIES_in), 32'd3);
    repeat (3) read_entry();

    // Fill to capacity and overflow.
    for (int i = 0; i < 32; i++)
      push_triplet(20'($urandom), 20'($urandom), 20'($urandom));
    check_val("full_entries", 32'(FIFO_ENTRIES_in), 32'd96);
    check_val("wm0_full", 32'(fifo_full), 32'd0);
    check_val("no_ovr_yet", 32'(FIFO_OVR), 32'd0);
    push_triplet(20'h55555, 20'h66666, 20'h77777);
    check_val("ovr_set", 32'(FIFO_OVR), 32'd1);
    check_val("ovr_entries", 32'(FIFO_ENTRIES_in), 32'd96);
    fifo_samples = 7'd100;
    tick(2);
    check_val("wm_clamp_full", 32'(fifo_full), 32'd1);
    fifo_samples = 7'd0;
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    tick(1);
    check_val("ovr_clr", 32'(FIFO_OVR), 32'd0);
    repeat (96) read_entry();

    // Watermark.
    fifo_samples = 7'd6;
    push_triplet(20'h00001, 20'h00002, 20'h00003);
    check_val("wm_below", 32'(fifo_full), 32'd0);
    push_triplet(20'h00004, 20'h00005, 20'h00006);
    tick(1);
    check_val("wm_entries", 32'(FIFO_ENTRIES_in), 32'd6);
    check_val("wm_reach", 32'(fifo_full), 32'd1);
    read_entry();
    tick(2);
    check_val("wm_drop", 32'(fifo_full), 32'd0);

    // Burst end mid-entry keeps the head.
    read_byte(0, 1'b1);
    read_byte(1, 1'b1);
    cs_n = 1'b1;
    tick(1);
    cs_n = 1'b0;
    tick(2);
    check_val("cs_keep", 32'(FIFO_ENTRIES_in), 32'd5);
    read_entry();

    // Pop on the same edge as the Y commit.
    read_byte(0, 1'b1);
    read_byte(1, 1'b1);
    read_byte(2, 1'b0);
    xdata_in = 20'hA0A0A; ydata_in = 20'hB0B0B; zdata_in = 20'hC0C0C;
    samp_valid = 1'b1;
    @(posedge mems_clk); #1;
    samp_valid = 1'b0;
    @(posedge mems_clk); #1;
    fifo_rd_en = 1'b1;
    @(negedge mems_clk);
    check_val("pre_pop", 32'(FIFO_ENTRIES_in), 32'd5);
    @(posedge mems_clk); #1;
    fifo_rd_en = 1'b0;
    @(negedge mems_clk);
    check_val("wry_pop", 32'(FIFO_ENTRIES_in), 32'd5);
    repeat (3) void'(exp_q.pop_front());
    push_entry(20'hA0A0A, 1'b1);
    push_entry(20'hB0B0B, 1'b0);
    push_entry(20'hC0C0C, 1'b0);
    model_entries = 6;
    tick(4);
    check_val("after_overlap", 32'(FIFO_ENTRIES_in), 32'd6);

    // samp_valid while the sequencer is busy overruns.
    xdata_in = 20'h11111; ydata_in = 20'h22222; zdata_in = 20'h33333;
    samp_valid = 1'b1;
    tick(2);
    samp_valid = 1'b0;
    tick(5);
    push_entry(20'h11111, 1'b1);
    push_entry(20'h22222, 1'b0);
    push_entry(20'h33333, 1'b0);
    model_entries = 9;
    check_val("busy_entries", 32'(FIFO_ENTRIES_in), 32'd9);
    check_val("busy_ovr", 32'(FIFO_OVR), 32'd1);

    // Standby flushes, keeps OVR, ignores samples.
    standby = 1'b1;
    tick(2);
    check_val("stby_entries", 32'(FIFO_ENTRIES_in), 32'd0);
    check_val("stby_ovr_kept", 32'(FIFO_OVR), 32'd1);
    check_val("stby_full", 32'(fifo_full), 32'd0);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    samp_valid = 1'b1;
    tick(1);
    samp_valid = 1'b0;
    tick(3);
    check_val("stby_no_ovr", 32'(FIFO_OVR), 32'd0);
    check_val("stby_no_write", 32'(FIFO_ENTRIES_in), 32'd0);
    standby = 1'b0;
    exp_q.delete();
    model_entries = 0;
    tick(2);
    read_empty_triplet();
    push_triplet(20'hFEDCB, 20'h98765, 20'h43210);
    repeat (3) read_entry();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
